// File: rtl/fft_stream_if.sv
// Stream interface for fft_stream_core: real samples in, complex bins out.
interface fft_stream_if #(
    parameter int unsigned IW = 16,
    parameter int unsigned DW = 24,
    parameter int unsigned LW = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [IW-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_real;
    logic signed [DW-1:0] out_imag;
    logic [LW-1:0]        out_idx;
    logic                 out_last;
    logic                 busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_real, out_imag, out_idx, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_real, out_imag, out_idx, out_last, busy
    );
endinterface

// File: rtl/fft_stream_core.sv
// Sequential radix-2 DIT FFT: buffers one N-point real frame, transforms it in
// place with one shared butterfly per cycle, streams bins out in natural order.
// Optional macro FFT_SCALE_EN: halve every butterfly output (result = DFT/N).
module fft_stream_core #(
    parameter int unsigned N  = 16,
    parameter int unsigned IW = 16,
    parameter int unsigned DW = 24
) (
    input  logic        clk,
    input  logic        rst,
    fft_stream_if.slave bus
);
    localparam int unsigned L  = $clog2(N);
    localparam int unsigned SW = $clog2(L);
    localparam int unsigned PW = DW + 17;
    localparam int unsigned AW = DW + 1;

    typedef enum logic [1:0] {S_LOAD, S_CALC, S_OUT} state_t;

    state_t               state_q, state_d;
    logic [L-1:0]         cnt_q, cnt_d;
    logic [SW-1:0]        stage_q, stage_d;
    logic [L-1:0]         out_idx_q, idx_d, idx_inc;
    logic signed [DW-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
    logic                 out_valid_q, out_last_q, in_ready_q, busy_q;
    logic                 ld_we, bf_we;

    logic signed [DW-1:0] mem_re [N];
    logic signed [DW-1:0] mem_im [N];

    logic [L-2:0]         j;
    logic [L-1:0]         pos, top, bot, ld_addr;
    logic [4:0]           tw_m;
    logic signed [15:0]   tw_c, tw_s;
    logic signed [DW-1:0] a_re, a_im, b_re, b_im, t_re, t_im;
    logic signed [PW-1:0] p_re, p_im;
    logic signed [DW-1:0] top_re_c, top_im_c, bot_re_c, bot_im_c;

    // Bit-reversed address of load index
    function automatic logic [L-1:0] bitrev(input logic [L-1:0] v);
        logic [L-1:0] r;
        for (int i = 0; i < L; i++) r[i] = v[L-1-i];
        return r;
    endfunction

    // First quadrant of the Q2.14 twiddle ROM: round(16384*cos(2*pi*i/64)), i = 0..16
    function automatic logic signed [15:0] qtr(input logic [4:0] i);
        case (i)
            5'd0:    return 16'sd16384;
            5'd1:    return 16'sd16305;
            5'd2:    return 16'sd16069;
            5'd3:    return 16'sd15679;
            5'd4:    return 16'sd15137;
            5'd5:    return 16'sd14449;
            5'd6:    return 16'sd13623;
            5'd7:    return 16'sd12665;
            5'd8:    return 16'sd11585;
            5'd9:    return 16'sd10394;
            5'd10:   return 16'sd9102;
            5'd11:   return 16'sd7723;
            5'd12:   return 16'sd6270;
            5'd13:   return 16'sd4756;
            5'd14:   return 16'sd3196;
            5'd15:   return 16'sd1606;
            default: return 16'sd0;
        endcase
    endfunction

    // Butterfly addressing, twiddle lookup and arithmetic for the current (stage, j)
    always_comb begin
        j     = cnt_q[L-2:0];
        pos   = L'(32'(j) & ((32'd1 << stage_q) - 32'd1));
        top   = L'(((32'(j) >> stage_q) << stage_q) << 1) | pos;
        bot   = top | L'(32'd1 << stage_q);
        tw_m  = 5'((32'(pos) << 5) >> stage_q);
        tw_c  = tw_m[4] ? -qtr(5'(5'd0 - tw_m)) : qtr(tw_m);
        tw_s  = tw_m[4] ? qtr(5'(tw_m - 5'd16)) : qtr(5'(5'd16 - tw_m));
        a_re  = mem_re[top];
        a_im  = mem_im[top];
        b_re  = mem_re[bot];
        b_im  = mem_im[bot];
        p_re  = PW'(b_re) * PW'(tw_c) + PW'(b_im) * PW'(tw_s) + PW'(8192);
        p_im  = PW'(b_im) * PW'(tw_c) - PW'(b_re) * PW'(tw_s) + PW'(8192);
        t_re  = DW'(p_re >>> 14);
        t_im  = DW'(p_im >>> 14);
`ifdef FFT_SCALE_EN
        top_re_c = DW'((AW'(a_re) + AW'(t_re)) >>> 1);
        top_im_c = DW'((AW'(a_im) + AW'(t_im)) >>> 1);
        bot_re_c = DW'((AW'(a_re) - AW'(t_re)) >>> 1);
        bot_im_c = DW'((AW'(a_im) - AW'(t_im)) >>> 1);
`else
        top_re_c = a_re + t_re;
        top_im_c = a_im + t_im;
        bot_re_c = a_re - t_re;
        bot_im_c = a_im - t_im;
`endif
    end

    // Next-state, counters and output next values
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stage_d  = stage_q;
        idx_d    = out_idx_q;
        out_re_d = out_re_q;
        out_im_d = out_im_q;
        ld_we    = 1'b0;
        bf_we    = 1'b0;
        ld_addr  = bitrev(cnt_q);
        idx_inc  = out_idx_q + L'(1);
        case (state_q)
            S_LOAD: begin
                if (bus.in_valid && bus.in_ready) begin
                    ld_we = 1'b1;
                    cnt_d = cnt_q + L'(1);
                    if (cnt_q == L'(N - 1)) begin
                        state_d = S_CALC;
                        cnt_d   = '0;
                        stage_d = '0;
                    end
                end
            end
            S_CALC: begin
                bf_we = 1'b1;
                cnt_d = cnt_q + L'(1);
                if (j == (L-1)'(N / 2 - 1)) begin
                    cnt_d = '0;
                    if (stage_q == SW'(L - 1)) begin
                        // Bin 0 was finalised earlier in the last stage, safe to read now
                        state_d  = S_OUT;
                        idx_d    = '0;
                        out_re_d = mem_re[0];
                        out_im_d = mem_im[0];
                    end else begin
                        stage_d = stage_q + SW'(1);
                    end
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    if (out_idx_q == L'(N - 1)) begin
                        state_d  = S_LOAD;
                        idx_d    = '0;
                        out_re_d = '0;
                        out_im_d = '0;
                    end else begin
                        idx_d    = idx_inc;
                        out_re_d = mem_re[idx_inc];
                        out_im_d = mem_im[idx_inc];
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_LOAD;
            cnt_q       <= '0;
            stage_q     <= '0;
            out_idx_q   <= '0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stage_q     <= stage_d;
            out_idx_q   <= idx_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            out_valid_q <= (state_d == S_OUT);
            out_last_q  <= (state_d == S_OUT) && (idx_d == L'(N - 1));
            in_ready_q  <= (state_d == S_LOAD);
            busy_q      <= (state_d != S_LOAD);
        end
    end

    // Frame memory: sample load or in-place butterfly write-back
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem_re[ld_addr] <= DW'($signed(bus.in_data));
            mem_im[ld_addr] <= '0;
        end else if (bf_we) begin
            mem_re[top] <= top_re_c;
            mem_im[top] <= top_im_c;
            mem_re[bot] <= bot_re_c;
            mem_im[bot] <= bot_im_c;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_real  = out_re_q;
    assign bus.out_imag  = out_im_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_fft_stream_core.sv
// Bench for fft_stream_core (N=16, IW=16, DW=24): directed table, random frames
// against a reference FFT, plus latency, backpressure and mid-CALC reset sequences.
module tb_fft_stream_core;
    localparam int unsigned NP  = 16;
    localparam int unsigned IWB = 16;
    localparam int unsigned DWB = 24;
    localparam int unsigned LB  = 4;
    localparam real         PI  = 3.14159265358979323846;
`ifdef FFT_SCALE_EN
    localparam bit SCALE = 1'b1;
`else
    localparam bit SCALE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_stream_if #(.IW(IWB), .DW(DWB), .LW(LB)) bus ();
    fft_stream_core #(.N(NP), .IW(IWB), .DW(DWB)) dut (.clk(clk), .rst(rst), .bus(bus));

    int     n_pass  = 0;
    int     n_total = 0;
    int     frame  [NP];
    longint ref_re [NP];
    longint ref_im [NP];
    longint got_re [NP];
    longint got_im [NP];

    typedef struct packed {
        int          x0;    // x[0]
        int          xe0;   // x[n], n%4==0, n>0
        int          xe2;   // x[n], n%4==2
        int          xodd;  // x[n], n odd
        logic [15:0] mask;  // bins holding val, every other bin 0
        int          val;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int rev4(input int n);
        int r = 0;
        for (int i = 0; i < int'(LB); i++) if (((n >> i) & 1) != 0) r |= 1 << (int'(LB) - 1 - i);
        return r;
    endfunction

    function automatic longint wrap_dw(input longint v);
        logic signed [DWB-1:0] t;
        t = DWB'(v);
        return longint'(t);
    endfunction

    function automatic longint fin(input longint v);
        return SCALE ? wrap_dw(v >>> 1) : wrap_dw(v);
    endfunction

    // Reference radix-2 DIT FFT on plain integers, twiddles from real trig
    function automatic void run_ref();
        longint re [NP];
        longint im [NP];
        int h, pos, top, bot, k;
        real ang;
        longint c, sn, tr, ti, ar, ai;
        for (int n = 0; n < int'(NP); n++) begin
            re[rev4(n)] = frame[n];
            im[rev4(n)] = 0;
        end
        for (int s = 0; s < int'(LB); s++) begin
            h = 1 << s;
            for (int jj = 0; jj < int'(NP) / 2; jj++) begin
                pos = jj % h;
                top = (jj / h) * 2 * h + pos;
                bot = top + h;
                k   = pos * int'(NP) / (2 * h);
                ang = 2.0 * PI * k / NP;
                c   = longint'($floor(16384.0 * $cos(ang) + 0.5));
                sn  = longint'($floor(16384.0 * $sin(ang) + 0.5));
                tr  = wrap_dw((re[bot] * c + im[bot] * sn + 8192) >>> 14);
                ti  = wrap_dw((im[bot] * c - re[bot] * sn + 8192) >>> 14);
                ar  = re[top];
                ai  = im[top];
                re[top] = fin(ar + tr);
                im[top] = fin(ai + ti);
                re[bot] = fin(ar - tr);
                im[bot] = fin(ai - ti);
            end
        end
        for (int n = 0; n < int'(NP); n++) begin
            ref_re[n] = re[n];
            ref_im[n] = im[n];
        end
    endfunction

    task automatic send_frame(input bit gaps, input bit hold_valid);
        int n = 0;
        int guard = 0;
        bit acc;
        while (n < int'(NP) && guard < 1000) begin
            bus.in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.in_data  = IWB'(frame[n]);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (acc) n++;
            guard++;
        end
        bus.in_valid = hold_valid;
        bus.in_data  = 16'sd7777;
        check("load_accepts", n, NP);
    endtask

    task automatic recv_frame(input bit stalls, input int stall_at, input string tag);
        int cnt = 0;
        int guard = 0;
        bit xfer;
        while (cnt < int'(NP) && guard < 3000) begin
            bus.out_ready = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (stall_at >= 0 && bus.out_valid && int'(bus.out_idx) == stall_at) begin
                bus.out_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(posedge clk); #1;
                    check($sformatf("%s stall%0d idx", tag, c), longint'(bus.out_idx), stall_at);
                    check($sformatf("%s stall%0d re", tag, c), longint'(bus.out_real), ref_re[stall_at]);
                    check($sformatf("%s stall%0d im", tag, c), longint'(bus.out_imag), ref_im[stall_at]);
                    check($sformatf("%s stall%0d valid", tag, c), longint'(bus.out_valid), 1);
                    check($sformatf("%s stall%0d in_ready", tag, c), longint'(bus.in_ready), 0);
                end
                stall_at = -1;
                bus.out_ready = 1'b1;
            end
            xfer = bus.out_valid && bus.out_ready;
            if (xfer) begin
                check($sformatf("%s idx@%0d", tag, cnt), longint'(bus.out_idx), cnt);
                check($sformatf("%s last@%0d", tag, cnt), longint'(bus.out_last), (cnt == int'(NP) - 1) ? 1 : 0);
                got_re[cnt] = longint'(bus.out_real);
                got_im[cnt] = longint'(bus.out_imag);
            end
            @(posedge clk); #1;
            if (xfer) cnt++;
            guard++;
        end
        bus.out_ready = 1'b0;
        check($sformatf("%s transfers", tag), cnt, NP);
        check($sformatf("%s valid_after", tag), longint'(bus.out_valid), 0);
        check($sformatf("%s in_ready_after", tag), longint'(bus.in_ready), 1);
    endtask

    task automatic compare_ref(input string tag);
        for (int k = 0; k < int'(NP); k++) begin
            check($sformatf("%s re[%0d]", tag, k), got_re[k], ref_re[k]);
            check($sformatf("%s im[%0d]", tag, k), got_im[k], ref_im[k]);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t vecs [5];
        int   lat, leak;
        bit   seen;

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst out_valid", longint'(bus.out_valid), 0);
        check("rst out_last", longint'(bus.out_last), 0);
        check("rst out_idx", longint'(bus.out_idx), 0);
        check("rst busy", longint'(bus.busy), 0);
        check("rst out_real", longint'(bus.out_real), 0);
        check("rst out_imag", longint'(bus.out_imag), 0);
        check("rst in_ready", longint'(bus.in_ready), 1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed frames with hand-derived spectra
        vecs[0] = '{x0: 256,  xe0: 0,    xe2: 0,     xodd: 0,    mask: 16'hFFFF, val: SCALE ? 16   : 256};
        vecs[1] = '{x0: 100,  xe0: 100,  xe2: 100,   xodd: 100,  mask: 16'h0001, val: SCALE ? 100  : 1600};
        vecs[2] = '{x0: 1000, xe0: 1000, xe2: -1000, xodd: 0,    mask: 16'h1010, val: SCALE ? 500  : 8000};
        vecs[3] = '{x0: -300, xe0: -300, xe2: -300,  xodd: -300, mask: 16'h0001, val: SCALE ? -300 : -4800};
        vecs[4] = '{x0: 500,  xe0: 500,  xe2: 500,   xodd: -500, mask: 16'h0100, val: SCALE ? 500  : 8000};
        for (int v = 0; v < 5; v++) begin
            for (int n = 0; n < int'(NP); n++)
                frame[n] = (n == 0) ? vecs[v].x0 : ((n % 2) != 0) ? vecs[v].xodd :
                           ((n % 4) == 2) ? vecs[v].xe2 : vecs[v].xe0;
            send_frame(1'b0, 1'b0);
            recv_frame(v[0], -1, $sformatf("vec%0d", v));
            for (int k = 0; k < int'(NP); k++) begin
                check($sformatf("vec%0d re[%0d]", v, k), got_re[k], vecs[v].mask[k] ? vecs[v].val : 0);
                check($sformatf("vec%0d im[%0d]", v, k), got_im[k], 0);
            end
        end

        // Random frames with gaps and stalls; first one holds at bin 3
        for (int f = 0; f < 4; f++) begin
            for (int n = 0; n < int'(NP); n++) frame[n] = int'($urandom_range(0, 65535)) - 32768;
            run_ref();
            send_frame(1'b1, 1'b0);
            recv_frame(1'b1, (f == 0) ? 3 : -1, $sformatf("rnd%0d", f));
            compare_ref($sformatf("rnd%0d", f));
        end

        // Latency with in_valid held high through CALC and OUT
        for (int n = 0; n < int'(NP); n++) frame[n] = int'($urandom_range(0, 4000)) - 2000;
        run_ref();
        send_frame(1'b0, 1'b1);
        lat  = 0;
        leak = 0;
        seen = 1'b0;
        for (int c = 1; c <= 200 && !seen; c++) begin
            if (bus.in_ready) leak++;
            @(posedge clk); #1;
            if (bus.out_valid) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        check("latency cycles", lat, 32);
        check("in_ready during calc", leak, 0);
        recv_frame(1'b0, -1, "lat");
        bus.in_valid = 1'b0;
        compare_ref("lat");

        // Reset ten cycles into CALC, then an impulse frame
        for (int n = 0; n < int'(NP); n++) frame[n] = int'($urandom_range(0, 65535)) - 32768;
        send_frame(1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check("calc busy", longint'(bus.busy), 1);
        rst = 1'b1;
        #1;
        check("midrst out_valid", longint'(bus.out_valid), 0);
        check("midrst busy", longint'(bus.busy), 0);
        check("midrst in_ready", longint'(bus.in_ready), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int n = 0; n < int'(NP); n++) frame[n] = (n == 0) ? 256 : 0;
        send_frame(1'b0, 1'b0);
        recv_frame(1'b0, -1, "postrst");
        for (int k = 0; k < int'(NP); k++) begin
            check($sformatf("postrst re[%0d]", k), got_re[k], SCALE ? 16 : 256);
            check($sformatf("postrst im[%0d]", k), got_im[k], 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/fft_stream_core.md
# fft_stream_core

Parametrised, sequential radix-2 decimation-in-time FFT core for the frequency-analysis datapath. It sits between the FIR filter output and the spectrum consumer. It accepts a real-valued sample stream with a valid/ready handshake and buffers one N-point frame. It then computes the transform in place with a single shared butterfly and streams the complex bins out in natural order. It generalises the fixed 16-point combinational FFT to configurable length and width, adds backpressure on both sides, and adds optional per-stage scaling.

## Interface
- N, 16: transform length; power of 2, 4..64. L = log2(N).
- IW, 16: input sample width, signed two's complement.
- DW, 24: internal and output word width per real/imag part, signed; DW >= IW.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input sample valid.
- in_ready  out  1  core can accept a sample; high only in LOAD.
- in_data  in  IW  real sample; imaginary part is implicitly 0.
- out_valid  out  1  bin valid; high only in OUT.
- out_ready  in  1  consumer accepts the bin.
- out_real  out  DW  real part of bin out_idx.
- out_imag  out  DW  imaginary part of bin out_idx.
- out_idx  out  L  bin index k, 0..N-1.
- out_last  out  1  high with out_valid when out_idx == N-1.
- busy  out  1  high in CALC or OUT.

## Operation
- State machine LOAD -> CALC -> OUT -> LOAD. Reset state is LOAD.
- Reset values: out_valid 0, out_last 0, out_idx 0, busy 0, out_real/out_imag 0, in_ready 1. Sample memory is not reset.
- LOAD:
  - On each in_valid && in_ready edge, sample n (0..N-1) is sign-extended to DW and written to address bitrev_L(n). imag is written as 0.
  - After sample N-1 is accepted, the core moves to CALC.
- CALC performs one butterfly per cycle over L stages, with N/2 butterflies per stage.
  - In stage s with h = 2^s, counter j runs 0..N/2-1. pos = j mod h; top = (j div h)*2h + pos; bot = top + h.
  - Twiddle W = cos(2πk/N) - j·sin(2πk/N), with k = pos·N/(2h).
  - Twiddles are read from a 32-entry Q2.14 ROM of cos/sin(2πm/64), m = k·64/N, rounded to nearest.
  - t = b·W, computed as:
    - t_re = (b_re·c + b_im·s + 2^13) >>> 14
    - t_im = (b_im·c − b_re·s + 2^13) >>> 14
  - Writes: top <= a + t, bot <= a − t. Results wrap to DW bits (two's complement); there is no saturation.
  - Memory reads are combinational and writes take effect at the clock edge, so stage s+1 sees all of stage s.
- OUT:
  - Presents bin out_idx from memory address out_idx, starting at 0.
  - out_idx increments on each out_valid && out_ready edge. out_real, out_imag and out_idx stay stable while out_ready is low.
  - On the transfer with out_last high, the core returns to LOAD.
- in_valid is ignored outside LOAD. out_ready is ignored outside OUT.
- rst asserted in any state returns the core to LOAD immediately and discards the partial frame or result.

## Timing
- Last sample accepted at edge E0. CALC occupies the next L·N/2 cycles. out_valid rises after edge E0 + L·N/2.
  - N=16: 32 cycles.
  - N=64: 192 cycles.
- in_ready rises in the cycle after the out_last transfer.
- Minimum frame period with no stalls: N + L·N/2 + N cycles.
- Outputs are registered or decoded from state only. There is no combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Configuration
- FFT_SCALE_EN defined: each butterfly output is arithmetically shifted right by 1 after the add/subtract (truncation toward −∞). The final result is DFT/N and cannot overflow for |x| < 2^(DW-2).
- FFT_SCALE_EN undefined: outputs are the unscaled DFT with wrap-around on overflow.

## Test plan
All cases use N=16, IW=16, DW=24.
- Impulse: x = {256, 0×15}, out_ready=1 -> every bin real=256, imag=0. With FFT_SCALE_EN: real=16.
- DC: x = 100 ×16 -> bin0 real=1600, all other bins exactly 0. With FFT_SCALE_EN: bin0=100.
- Tone: x[n] = 1000·cos(πn/2), i.e. pattern {1000, 0, −1000, 0} -> bins 4 and 12 real=8000, all other bins and all imag exactly 0.
- Backpressure: out_ready low for 5 cycles while out_idx=3 -> out_idx, out_real and out_imag stay stable and in_ready=0. Exactly 16 transfers occur, and out_last is high only at idx 15.
- Latency: in_valid held high, out_ready=1 -> out_valid first high 32 cycles after the 16th accept edge. in_ready returns 1 the cycle after the out_last transfer. Extra in_valid beats during CALC/OUT are not accepted.
- Reset mid-CALC: assert rst 10 cycles into CALC -> out_valid=0, busy=0, in_ready=1 immediately. The next impulse frame yields 256 in every bin.
